// File: rtl/lsu_bus_adapter_if.sv
// Core-request / memory-bus bundle for the LSU bus adapter.
// The master modport is the adapter's view; slave is the core+memory side.
interface lsu_bus_adapter_if #(parameter int XLEN = 32);
  logic            req_valid, req_ready, req_write, req_zext;
  logic [1:0]      req_size;
  logic [XLEN-1:0] req_addr, req_wdata;
  logic            rsp_valid, rsp_fault;
  logic [XLEN-1:0] rsp_rdata;
  logic            mem_req, mem_gnt, mem_we, mem_rvalid;
  logic [XLEN/8-1:0] mem_be;
  logic [XLEN-1:0] mem_addr, mem_wdata, mem_rdata;

  modport master (
    input  req_valid, req_write, req_size, req_zext, req_addr, req_wdata,
           mem_gnt, mem_rvalid, mem_rdata,
    output req_ready, rsp_valid, rsp_rdata, rsp_fault,
           mem_req, mem_we, mem_be, mem_addr, mem_wdata
  );

  modport slave (
    output req_valid, req_write, req_size, req_zext, req_addr, req_wdata,
           mem_gnt, mem_rvalid, mem_rdata,
    input  req_ready, rsp_valid, rsp_rdata, rsp_fault,
           mem_req, mem_we, mem_be, mem_addr, mem_wdata
  );
endinterface

// File: rtl/lsu_bus_adapter.sv
// Single-outstanding load/store adapter: aligns core accesses onto a
// bus-word-wide memory port, extends load data, and faults on misalignment/timeout.
module lsu_bus_adapter #(
  parameter int XLEN           = 32,
  parameter int TIMEOUT_CYCLES = 16
) (
  input logic               clk,
  input logic               rst_n,
  lsu_bus_adapter_if.master bus
);
  localparam int NUM_LANES = XLEN / 8;
  localparam int OFFW      = $clog2(NUM_LANES);
  localparam int CW        = $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic [1:0] {IDLE, REQ, WAIT, RESP} state_t;

  typedef struct packed {
    logic            write;
    logic [1:0]      size;
    logic            zext;
    logic [OFFW-1:0] off;
  } req_t;

  state_t  state;
  req_t    req_q;
  logic [CW-1:0] cnt;

  logic [OFFW-1:0] off_in;
  logic [3:0]      nbytes;
  logic            misaligned;
  logic            timeout;
  logic [NUM_LANES-1:0]      be_n;
  logic [NUM_LANES-1:0][7:0] wbytes;
  logic [XLEN-1:0] lane_data, load_data;

  assign off_in  = bus.req_addr[OFFW-1:0];
  assign timeout = (cnt == CW'(TIMEOUT_CYCLES - 1));

  always_comb begin
    nbytes = 4'd8;
    case (bus.req_size)
      2'b00:   nbytes = 4'd1;
      2'b01:   nbytes = 4'd2;
      2'b11:   nbytes = 4'd4;
      default: nbytes = 4'd8;
    endcase
  end

  always_comb begin
    misaligned = 1'b0;
    case (bus.req_size)
      2'b00:   misaligned = 1'b0;
      2'b01:   misaligned = bus.req_addr[0];
      2'b11:   misaligned = |bus.req_addr[1:0];
      default: misaligned = (XLEN == 32) || (|bus.req_addr[2:0]);
    endcase
  end

  // Each bus lane picks its source byte relative to the access offset.
  for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
    logic [OFFW-1:0] rel;
    assign rel       = OFFW'(i) - off_in;
    assign be_n[i]   = (OFFW'(i) >= off_in) && (4'(rel) < nbytes);
    assign wbytes[i] = be_n[i] ? bus.req_wdata[{rel, 3'b000} +: 8] : 8'h00;
  end

  assign lane_data = bus.mem_rdata >> {req_q.off, 3'b000};

  always_comb begin
    load_data = lane_data;
    case (req_q.size)
      2'b00:   load_data = req_q.zext ? XLEN'(lane_data[7:0])  : XLEN'($signed(lane_data[7:0]));
      2'b01:   load_data = req_q.zext ? XLEN'(lane_data[15:0]) : XLEN'($signed(lane_data[15:0]));
      2'b11:   load_data = req_q.zext ? XLEN'(lane_data[31:0]) : XLEN'($signed(lane_data[31:0]));
      default: load_data = lane_data;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= IDLE;
      req_q         <= '0;
      cnt           <= '0;
      bus.req_ready <= 1'b1;
      bus.rsp_valid <= 1'b0;
      bus.rsp_fault <= 1'b0;
      bus.rsp_rdata <= '0;
      bus.mem_req   <= 1'b0;
      bus.mem_we    <= 1'b0;
      bus.mem_be    <= '0;
      bus.mem_addr  <= '0;
      bus.mem_wdata <= '0;
    end else begin
      bus.rsp_valid <= 1'b0;
      case (state)
        IDLE: if (bus.req_valid) begin
          req_q         <= '{bus.req_write, bus.req_size, bus.req_zext, off_in};
          cnt           <= '0;
          bus.req_ready <= 1'b0;
          if (misaligned) begin
            state         <= RESP;
            bus.rsp_valid <= 1'b1;
            bus.rsp_fault <= 1'b1;
            bus.rsp_rdata <= '0;
          end else begin
            state         <= REQ;
            bus.mem_req   <= 1'b1;
            bus.mem_we    <= bus.req_write;
            bus.mem_be    <= be_n;
            bus.mem_addr  <= {bus.req_addr[XLEN-1:OFFW], {OFFW{1'b0}}};
            bus.mem_wdata <= wbytes;
          end
        end
        REQ: begin
          cnt <= cnt + 1'b1;
          // Timeout beats a grant arriving on the same edge.
          if (timeout) begin
            state         <= RESP;
            bus.mem_req   <= 1'b0;
            bus.rsp_valid <= 1'b1;
            bus.rsp_fault <= 1'b1;
            bus.rsp_rdata <= '0;
          end else if (bus.mem_gnt) begin
            state       <= WAIT;
            bus.mem_req <= 1'b0;
          end
        end
        WAIT: begin
          cnt <= cnt + 1'b1;
          // Data arriving on the timeout cycle still completes normally.
          if (bus.mem_rvalid) begin
            state         <= RESP;
            bus.rsp_valid <= 1'b1;
            bus.rsp_fault <= 1'b0;
            bus.rsp_rdata <= req_q.write ? '0 : load_data;
          end else if (timeout) begin
            state         <= RESP;
            bus.rsp_valid <= 1'b1;
            bus.rsp_fault <= 1'b1;
            bus.rsp_rdata <= '0;
          end
        end
        default: begin
          state         <= IDLE;
          bus.req_ready <= 1'b1;
          bus.rsp_fault <= 1'b0;
          bus.rsp_rdata <= '0;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_lsu_bus_adapter.sv
// Directed bench for lsu_bus_adapter: a 32-bit instance with an 8-cycle
// timeout and a 64-bit instance with the default timeout.
module tb_lsu_bus_adapter;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  lsu_bus_adapter_if #(.XLEN(32)) b32();
  lsu_bus_adapter_if #(.XLEN(64)) b64();

  lsu_bus_adapter #(.XLEN(32), .TIMEOUT_CYCLES(8)) dut32 (.clk(clk), .rst_n(rst_n), .bus(b32));
  lsu_bus_adapter #(.XLEN(64))                     dut64 (.clk(clk), .rst_n(rst_n), .bus(b64));

  int n_cmp = 0;
  int n_bad = 0;
  bit sel64 = 1'b0;

  logic [63:0] mem_addr_o, mem_wdata_o, rsp_rdata_o;
  logic [7:0]  mem_be_o;
  logic        mem_req_o, mem_we_o, rsp_valid_o, rsp_fault_o, req_ready_o;

  always_comb begin
    mem_addr_o  = sel64 ? b64.mem_addr  : {32'h0, b32.mem_addr};
    mem_wdata_o = sel64 ? b64.mem_wdata : {32'h0, b32.mem_wdata};
    rsp_rdata_o = sel64 ? b64.rsp_rdata : {32'h0, b32.rsp_rdata};
    mem_be_o    = sel64 ? b64.mem_be    : {4'h0, b32.mem_be};
    mem_req_o   = sel64 ? b64.mem_req   : b32.mem_req;
    mem_we_o    = sel64 ? b64.mem_we    : b32.mem_we;
    rsp_valid_o = sel64 ? b64.rsp_valid : b32.rsp_valid;
    rsp_fault_o = sel64 ? b64.rsp_fault : b32.rsp_fault;
    req_ready_o = sel64 ? b64.req_ready : b32.req_ready;
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic nclk();
    @(negedge clk);
  endtask

  task automatic drive(input bit v, input bit wr, input logic [1:0] sz, input bit zx,
                       input logic [63:0] a, input logic [63:0] d);
    if (sel64) begin
      b64.req_valid = v; b64.req_write = wr; b64.req_size = sz; b64.req_zext = zx;
      b64.req_addr = a;  b64.req_wdata = d;
    end else begin
      b32.req_valid = v; b32.req_write = wr; b32.req_size = sz; b32.req_zext = zx;
      b32.req_addr = a[31:0]; b32.req_wdata = d[31:0];
    end
  endtask

  task automatic bus_in(input bit gnt, input bit rv, input logic [63:0] rd);
    if (sel64) begin
      b64.mem_gnt = gnt; b64.mem_rvalid = rv; b64.mem_rdata = rd;
    end else begin
      b32.mem_gnt = gnt; b32.mem_rvalid = rv; b32.mem_rdata = rd[31:0];
    end
  endtask

  // Aligned access: grant in the first REQ cycle, data the cycle after.
  task automatic aligned(input string tag, input bit wr, input logic [1:0] sz, input bit zx,
                         input logic [63:0] a, input logic [63:0] d, input logic [63:0] rd,
                         input logic [63:0] ea, input logic [7:0] ebe,
                         input logic [63:0] ewd, input logic [63:0] erd);
    drive(1'b1, wr, sz, zx, a, d);
    nclk();
    drive(1'b0, 1'b0, 2'b00, 1'b0, 64'h0, 64'h0);
    chk({tag, ".mem_req"}, mem_req_o, 1);
    chk({tag, ".mem_addr"}, mem_addr_o, ea);
    chk({tag, ".mem_be"}, mem_be_o, ebe);
    chk({tag, ".mem_wdata"}, mem_wdata_o, ewd);
    chk({tag, ".mem_we"}, mem_we_o, wr);
    chk({tag, ".busy"}, req_ready_o, 0);
    bus_in(1'b1, 1'b0, 64'h0);
    nclk();
    bus_in(1'b0, 1'b1, rd);
    chk({tag, ".req_drop"}, mem_req_o, 0);
    chk({tag, ".no_early_rsp"}, rsp_valid_o, 0);
    nclk();
    bus_in(1'b0, 1'b0, 64'h0);
    chk({tag, ".rsp_valid"}, rsp_valid_o, 1);
    chk({tag, ".rsp_rdata"}, rsp_rdata_o, erd);
    chk({tag, ".rsp_fault"}, rsp_fault_o, 0);
    nclk();
    chk({tag, ".rsp_one_cycle"}, rsp_valid_o, 0);
    chk({tag, ".ready_again"}, req_ready_o, 1);
  endtask

  task automatic misal(input string tag, input bit wr, input logic [1:0] sz, input logic [63:0] a);
    drive(1'b1, wr, sz, 1'b0, a, 64'hFFFF_FFFF_FFFF_FFFF);
    nclk();
    drive(1'b0, 1'b0, 2'b00, 1'b0, 64'h0, 64'h0);
    chk({tag, ".rsp_valid"}, rsp_valid_o, 1);
    chk({tag, ".rsp_fault"}, rsp_fault_o, 1);
    chk({tag, ".rsp_rdata"}, rsp_rdata_o, 0);
    chk({tag, ".no_mem_req"}, mem_req_o, 0);
    nclk();
    chk({tag, ".rsp_one_cycle"}, rsp_valid_o, 0);
    chk({tag, ".no_mem_req2"}, mem_req_o, 0);
    chk({tag, ".ready_again"}, req_ready_o, 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog expired");
  end

  initial begin
    sel64 = 1'b1; drive(0, 0, 2'b00, 0, 0, 0); bus_in(0, 0, 0);
    sel64 = 1'b0; drive(0, 0, 2'b00, 0, 0, 0); bus_in(0, 0, 0);
    repeat (2) nclk();
    chk("rst.during.mem_req", mem_req_o, 0);
    rst_n = 1'b1;
    nclk();
    for (int s = 0; s < 2; s++) begin
      sel64 = (s == 1);
      chk("rst.req_ready", req_ready_o, 1);
      chk("rst.rsp_valid", rsp_valid_o, 0);
      chk("rst.rsp_fault", rsp_fault_o, 0);
      chk("rst.rsp_rdata", rsp_rdata_o, 0);
      chk("rst.mem_req", mem_req_o, 0);
      chk("rst.mem_we", mem_we_o, 0);
      chk("rst.mem_be", mem_be_o, 0);
      chk("rst.mem_addr", mem_addr_o, 0);
      chk("rst.mem_wdata", mem_wdata_o, 0);
    end
    sel64 = 1'b0;

    aligned("lb",  0, 2'b00, 0, 64'h1003, 64'h0, 64'h8012_3456, 64'h1000, 8'b1000, 64'h0, 64'hFFFF_FF80);
    aligned("lhu", 0, 2'b01, 1, 64'h0002, 64'h0, 64'hBEEF_1234, 64'h0000, 8'b1100, 64'h0, 64'h0000_BEEF);
    aligned("lh",  0, 2'b01, 0, 64'h0002, 64'h0, 64'hBEEF_1234, 64'h0000, 8'b1100, 64'h0, 64'hFFFF_BEEF);
    aligned("lbu", 0, 2'b00, 1, 64'h0001, 64'h0, 64'h0000_F000, 64'h0000, 8'b0010, 64'h0, 64'h0000_00F0);
    aligned("lw",  0, 2'b11, 0, 64'h0008, 64'h0, 64'h1234_5678, 64'h0008, 8'b1111, 64'h0, 64'h1234_5678);
    aligned("sb",  1, 2'b00, 0, 64'h0005, 64'hA5, 64'hFFFF_FFFF, 64'h0004, 8'b0010, 64'h0000_A500, 64'h0);
    aligned("sh",  1, 2'b01, 0, 64'h0006, 64'hDEAD_BEEF, 64'h0, 64'h0004, 8'b1100, 64'hBEEF_0000, 64'h0);

    misal("sw_mis", 1, 2'b11, 64'h1);
    misal("ld_x32", 0, 2'b10, 64'h0);
    misal("lh_mis", 0, 2'b01, 64'h3);

    // No grant: request held for the full timeout, stray rvalid in REQ ignored.
    drive(1, 0, 2'b11, 0, 64'h10, 64'h0);
    nclk();
    drive(0, 0, 2'b00, 0, 64'h0, 64'h0);
    for (int k = 1; k <= 8; k++) begin
      chk("to.mem_req_held", mem_req_o, 1);
      chk("to.mem_addr_stable", mem_addr_o, 64'h10);
      chk("to.no_rsp", rsp_valid_o, 0);
      bus_in(0, (k == 3), 64'hFFFF_FFFF);
      nclk();
    end
    bus_in(0, 0, 0);
    chk("to.mem_req_drop", mem_req_o, 0);
    chk("to.rsp_valid", rsp_valid_o, 1);
    chk("to.rsp_fault", rsp_fault_o, 1);
    chk("to.rsp_rdata", rsp_rdata_o, 0);
    nclk();
    chk("to.ready_again", req_ready_o, 1);

    // Data on the same cycle the counter expires wins.
    drive(1, 0, 2'b11, 0, 64'h14, 64'h0);
    nclk();
    drive(0, 0, 2'b00, 0, 64'h0, 64'h0);
    bus_in(1, 0, 0);
    nclk();
    bus_in(0, 0, 0);
    chk("race.in_wait", mem_req_o, 0);
    for (int k = 2; k < 8; k++) begin
      chk("race.no_rsp_yet", rsp_valid_o, 0);
      nclk();
    end
    bus_in(0, 1, 64'hCAFE_F00D);
    nclk();
    bus_in(0, 0, 0);
    chk("race.rsp_valid", rsp_valid_o, 1);
    chk("race.rsp_fault", rsp_fault_o, 0);
    chk("race.rsp_rdata", rsp_rdata_o, 64'hCAFE_F00D);
    nclk();
    chk("race.ready_again", req_ready_o, 1);

    sel64 = 1'b1;
    aligned("ld64", 0, 2'b10, 0, 64'h8, 64'h0, 64'hFEDC_BA98_7654_3210, 64'h8, 8'hFF, 64'h0, 64'hFEDC_BA98_7654_3210);
    aligned("lw64", 0, 2'b11, 0, 64'hC, 64'h0, 64'h8000_0000_0000_0000, 64'h8, 8'hF0, 64'h0, 64'hFFFF_FFFF_8000_0000);
    aligned("sw64", 1, 2'b11, 0, 64'h1C, 64'h1122_3344, 64'h0, 64'h18, 8'hF0, 64'h1122_3344_0000_0000, 64'h0);
    misal("ld64_mis", 0, 2'b10, 64'h4);

    // Reset while waiting for data: transaction is dropped, late data ignored.
    drive(1, 0, 2'b10, 0, 64'h8, 64'h0);
    nclk();
    drive(0, 0, 2'b00, 0, 64'h0, 64'h0);
    bus_in(1, 0, 0);
    nclk();
    bus_in(0, 0, 0);
    chk("rstw.in_wait", mem_req_o, 0);
    rst_n = 1'b0;
    #1;
    chk("rstw.async_be", mem_be_o, 0);
    chk("rstw.async_rsp", rsp_valid_o, 0);
    nclk();
    rst_n = 1'b1;
    bus_in(0, 1, 64'h1234);
    nclk();
    bus_in(0, 0, 0);
    chk("rstw.no_rsp", rsp_valid_o, 0);
    chk("rstw.ready", req_ready_o, 1);
    nclk();
    chk("rstw.no_rsp2", rsp_valid_o, 0);
    chk("rstw.no_mem_req", mem_req_o, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/lsu_bus_adapter.md
LSU_BUS_ADAPTER -- requirements
Module: lsu_bus_adapter

Interface
REQ-001 Parameter XLEN, default 32, data/address width; SHALL accept 32 or 64.
REQ-002 Parameter TIMEOUT_CYCLES, default 16, bus cycles allowed from entering REQ to mem_rvalid before fault; SHALL be >= 2.
REQ-003 clk  in  1  sole clock; all state SHALL update on its rising edge.
REQ-004 rst_n  in  1  reset; SHALL be asynchronous, active-low.
REQ-005 req_valid  in  1 / req_ready  out  1  core request handshake.
REQ-006 req_write  in  1 (1=store) / req_size  in  2 (00 byte, 01 half, 11 word, 10 doubleword) / req_zext  in  1 (zero-extend load).
REQ-007 req_addr  in  XLEN / req_wdata  in  XLEN  byte address and store data (right-aligned).
REQ-008 rsp_valid  out  1 / rsp_rdata  out  XLEN / rsp_fault  out  1  one-cycle response to core.
REQ-009 mem_req  out  1 / mem_gnt  in  1 / mem_we  out  1 / mem_be  out  XLEN/8 / mem_addr  out  XLEN / mem_wdata  out  XLEN  bus request channel.
REQ-010 mem_rvalid  in  1 / mem_rdata  in  XLEN  bus response (read data or store ack).

Function
REQ-011 FSM states IDLE, REQ, WAIT, RESP; req_ready SHALL be 1 only in IDLE.
REQ-012 Acceptance = req_valid & req_ready; request fields SHALL be registered on acceptance and held until RESP exits.
REQ-013 Misaligned/illegal: half with addr[0]!=0, word with addr[1:0]!=0, doubleword with addr[2:0]!=0, or doubleword when XLEN=32 -> next state RESP, rsp_fault=1, rsp_rdata=0, no mem_req.
REQ-014 Aligned accept -> REQ; mem_req=1 in REQ only; mem_addr = req_addr with low log2(XLEN/8) bits cleared; mem_we = req_write.
REQ-015 mem_be SHALL be size mask (1, 2, 4 or 8 ones) shifted left by address offset within the bus word.
REQ-016 mem_wdata SHALL be req_wdata shifted left by 8*offset; unused lanes 0.
REQ-017 REQ -> WAIT on mem_gnt; mem_* outputs SHALL remain stable while mem_req=1 and mem_gnt=0.
REQ-018 mem_rvalid SHALL be honoured only in WAIT (earliest cycle after grant); ignored elsewhere.
REQ-019 WAIT -> RESP on mem_rvalid; for loads rsp_rdata = selected lane shifted down, sign-extended from its MSB unless req_zext=1; doubleword ignores req_zext; stores rsp_rdata=0; rsp_fault=0.
REQ-020 Timeout counter SHALL clear on acceptance, increment each cycle in REQ/WAIT; reaching TIMEOUT_CYCLES -> RESP, rsp_fault=1, rsp_rdata=0, mem_req dropped same edge.
REQ-021 mem_rvalid in WAIT on same cycle as timeout SHALL win: normal response, fault=0.
REQ-022 RESP: rsp_valid=1 exactly one cycle, then IDLE; no back-pressure on response.
REQ-023 Latency: aligned access with gnt in first REQ cycle and rvalid next cycle SHALL give rsp_valid 3 cycles after acceptance; misaligned SHALL give rsp_valid 1 cycle after acceptance.
REQ-024 At most one outstanding transaction; new request SHALL not be accepted before RESP completes.

Reset
REQ-025 rst_n low SHALL force IDLE immediately; req_ready=1 after release; rsp_valid, rsp_fault, mem_req, mem_we=0; rsp_rdata, mem_addr, mem_wdata, mem_be=0; counter=0.
REQ-026 Reset mid-transaction SHALL abandon it: no rsp_valid produced; late mem_rvalid after release ignored.

Verification
REQ-027 XLEN=32, LB addr 0x1003, mem_rdata 0x80123456 -> mem_addr 0x1000, mem_be 4'b1000, rsp_rdata 0xFFFFFF80, fault 0.
REQ-028 LHU addr 0x0002, mem_rdata 0xBEEF1234 -> mem_be 4'b1100, rsp_rdata 0x0000BEEF.
REQ-029 SB addr 0x0005, wdata 0x000000A5 -> mem_addr 0x4, mem_be 4'b0010, mem_wdata 0x0000A500, mem_we 1; rvalid ack -> rsp_rdata 0.
REQ-030 SW addr 0x0001 -> no mem_req, rsp_valid next cycle, rsp_fault 1; XLEN=32 doubleword addr 0x0 -> same.
REQ-031 TIMEOUT_CYCLES=8, mem_gnt held 0 -> mem_req 8 cycles then drop, rsp_fault 1; repeat with rvalid on the 8th counted cycle -> fault 0.
REQ-032 XLEN=64, LD addr 0x8, mem_rdata 0xFEDCBA9876543210 -> mem_be 8'hFF, rsp_rdata unchanged; assert rst_n low in WAIT -> no rsp_valid, req_ready 1 after release.
